seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
- Downstream consumer of the memory-mapped output port registers.
- Takes one 32-bit output-port word (8 hex digits) plus a decimal-point mask and time-multiplexes them onto an 8-digit common-anode seven-segment display.
- Snapshots the input once per scan frame so a CPU store mid-frame never tears the displayed value.
- Optional leading-zero blanking and a frame-done pulse for software or bench sync.

Parameters:
- DIV, 50000, io_clk cycles each digit stays active (≥1; 50 MHz → 1 kHz digit rate).
- LZB, 1, leading-zero blanking enable (1 = blank leading zero digits, 0 = show all 8).

Ports:
- io_clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- data  input  32  hex value to display; nibble k drives digit k (digit 0 = rightmost).
- dp_mask  input  8  bit k = 1 lights the decimal point of digit k.
- enable  input  1  1 = scanning and display on; 0 = display dark, scan frozen.
- an  output  8  digit anodes, active low, one-hot-zero.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.
- frame_done  output  1  one-cycle pulse when a new snapshot is loaded.

Behaviour:
- Reset (async, resetn=0):
  - prescaler cnt=0, digit index idx=0, shadow_data=0, shadow_dp=0.
  - an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
  - Reset applied mid-scan aborts the scan immediately; no partial state survives.
- Prescaler:
  - While enable=1, cnt counts 0..DIV-1 and wraps; tick = (cnt==DIV-1).
  - DIV=1 gives tick every cycle.
- Digit index:
  - Increments on each tick and wraps 7→0, so each idx value is held exactly DIV cycles and one frame is 8·DIV cycles.
- Snapshot: on the edge where idx wraps 7→0, shadow_data←data, shadow_dp←dp_mask, and frame_done=1 for that one cycle.
  - data/dp_mask changes at any other time are invisible until the next wrap.
  - The first frame after reset displays shadow=0.
- Outputs: registered, 1-cycle latency from idx/shadow.
  - an = ~(1<<idx).
  - seg = decode(shadow_data[4·idx+3:4·idx]).
  - dp = ~shadow_dp[idx].
- Decode, active low, hex 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Leading-zero blanking (LZB=1):
  - Digit k (1..7) is blanked (seg=7F, dp still per mask) when nibbles k..7 of shadow_data are all zero.
  - Digit 0 is never blanked.
  - an still selects the digit, so brightness stays uniform.
- enable=0:
  - cnt, idx and shadow hold; no frame_done.
  - an=FF, seg=7F, dp=1 from the next cycle.
  - When enable returns to 1, scanning resumes from the held cnt/idx.
- Simultaneous data change and wrap edge: the value sampled on that edge is loaded.

Test Plan:
- Reset: hold resetn=0 with arbitrary data and enable=1 → an=FF, seg=7F, dp=1, frame_done=0; after release the first an=FE appears 1 cycle later.
- Scan timing, DIV=4, LZB=0, enable=1: an sequence FE,FD,FB,F7,EF,DF,BF,7F with each held 4 cycles; frame_done pulses once every 32 cycles at the 7→0 wrap.
- Decode, DIV=4, LZB=0, data=0x0123_89AF loaded at first wrap → digits 0..7 show seg 0E,08,10,00,30,24,79,40; dp_mask=0x01 → dp=0 only while an=FE.
- Snapshot: change data from 0x1111_1111 to 0x2222_2222 while idx=3 → remaining digits of the frame still show 79; after the wrap all digits show 24.
- Leading-zero blanking, LZB=1, data=0x0000_00A0 → digits 2..7 show seg 7F, digit 1 shows 08, digit 0 shows 40; data=0 → only digit 0 shows 40.
- Enable and reset mid-scan:
  - Drop enable at idx=5 for 10 cycles → an=FF throughout; scanning resumes at idx=5 with the remaining cnt.
  - Pulse resetn low mid-frame → outputs go to reset values immediately; after release the first frame displays 0.

Source files
------------

// File: rtl/seg7_scan_display.sv
// Eight-digit common-anode seven-segment scanner: snapshots a 32-bit hex word
// plus decimal-point mask once per frame and time-multiplexes it onto the display.
module seg7_scan_display #(
  parameter int unsigned DIV = 50000,
  parameter bit          LZB = 1'b1
) (
  input  logic        io_clk,
  input  logic        resetn,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic        enable,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      shadow_data;
  logic [7:0]       shadow_dp;

  logic       tick_c;
  logic       wrap_c;
  logic [3:0] nib_c;
  logic       blank_c;
  logic [6:0] seg_c;

  assign tick_c = enable && (cnt == CNT_MAX);
  assign wrap_c = tick_c && (idx == 3'd7);
  assign nib_c  = shadow_data[{idx, 2'b00} +: 4];

  // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
  always_comb begin
    blank_c = 1'b0;
    if (LZB && (idx != 3'd0)) begin
      blank_c = ((shadow_data >> {idx, 2'b00}) == 32'd0);
    end
  end

  // Hex to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    seg_c = 7'h7F;
    case (nib_c)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end

  // Prescaler, digit index and per-frame snapshot; everything freezes while disabled.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      cnt         <= '0;
      idx         <= 3'd0;
      shadow_data <= 32'd0;
      shadow_dp   <= 8'd0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= wrap_c;
      if (enable) begin
        cnt <= tick_c ? '0 : cnt + 1'b1;
        if (tick_c) begin
          idx <= idx + 3'd1;
        end
        if (wrap_c) begin
          shadow_data <= data;
          shadow_dp   <= dp_mask;
        end
      end
    end
  end

  // Registered display drive; dark while disabled.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else if (enable) begin
      an  <= ~(8'd1 << idx);
      seg <= blank_c ? 7'h7F : seg_c;
      dp  <= ~shadow_dp[idx];
    end else begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: two instances (blanking off / on) at DIV=4 share
// stimulus; per-frame expectations are queued when data is driven and popped per digit.
module tb_seg7_scan_display;

  logic        io_clk = 1'b0;
  logic        resetn;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic        enable;
  logic [7:0]  an, an_b;
  logic [6:0]  seg, seg_b;
  logic        dp, dp_b;
  logic        frame_done, frame_done_b;

  always #5 io_clk = ~io_clk;

  seg7_scan_display #(.DIV(4), .LZB(1'b0)) dut (
    .io_clk(io_clk), .resetn(resetn), .data(data), .dp_mask(dp_mask), .enable(enable),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  seg7_scan_display #(.DIV(4), .LZB(1'b1)) dut_lzb (
    .io_clk(io_clk), .resetn(resetn), .data(data), .dp_mask(dp_mask), .enable(enable),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_done(frame_done_b)
  );

  typedef struct {
    logic [31:0]     data;
    logic [7:0]      mask;
    logic [7:0][6:0] seg_l0;
    logic [7:0][6:0] seg_l1;
  } vec_t;

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic [6:0] seg_lzb;
    logic       dp;
  } exp_t;

  vec_t vec[5];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0][6:0] s0, input logic [7:0][6:0] s1,
                            input logic [7:0] mask);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.an      = 8'(~(8'd1 << k));
      e.seg     = s0[k];
      e.seg_lzb = s1[k];
      e.dp      = ~mask[k];
      sb.push_back(e);
    end
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hFF);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp"}, 32'(dp), 32'h1);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
    chk({tag, "_an_lzb"}, 32'(an_b), 32'hFF);
    chk({tag, "_seg_lzb"}, 32'(seg_b), 32'h7F);
  endtask

  task automatic wait_frame();
    bit got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge io_clk); #1;
      if (frame_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_frame_done", 32'(got), 32'h1);
  endtask

  // Check one full frame (8 digits x 4 cycles) starting at the next clock edge.
  task automatic check_frame(input bit do_mid, input logic [31:0] mid_data);
    exp_t e;
    for (int d = 0; d < 8; d++) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at t=%0t", $time);
        e = '{8'hFF, 7'h7F, 7'h7F, 1'b1};
      end else begin
        e = sb.pop_front();
      end
      for (int c = 0; c < 4; c++) begin
        @(posedge io_clk); #1;
        chk("an", 32'(an), 32'(e.an));
        chk("seg", 32'(seg), 32'(e.seg));
        chk("dp", 32'(dp), 32'(e.dp));
        chk("an_lzb", 32'(an_b), 32'(e.an));
        chk("seg_lzb", 32'(seg_b), 32'(e.seg_lzb));
        chk("dp_lzb", 32'(dp_b), 32'(e.dp));
        chk("frame_done", 32'(frame_done), 32'(d == 7 && c == 3));
        if (do_mid && d == 3 && c == 0) data = mid_data;
      end
    end
  endtask

  initial begin
    logic [7:0] an_exp;
    int         j;

    vec[0] = '{32'h0123_89AF, 8'h01,
               {7'h40, 7'h79, 7'h24, 7'h30, 7'h00, 7'h10, 7'h08, 7'h0E},
               {7'h7F, 7'h79, 7'h24, 7'h30, 7'h00, 7'h10, 7'h08, 7'h0E}};
    vec[1] = '{32'h0000_00A0, 8'h80,
               {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h40},
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40}};
    vec[2] = '{32'h0000_0000, 8'h00,
               {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
               {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vec[3] = '{32'hFEDC_BA98, 8'hA5,
               {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00},
               {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}};
    vec[4] = '{32'h0050_0000, 8'h5A,
               {7'h40, 7'h40, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40},
               {7'h7F, 7'h7F, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};

    // Reset held with live data and enable: display stays dark.
    resetn  = 1'b0;
    enable  = 1'b1;
    data    = 32'hDEAD_BEEF;
    dp_mask = 8'hFF;
    repeat (3) begin
      @(posedge io_clk); #1;
      check_dark("reset");
    end

    // First frame after reset shows the zeroed shadow, not the live data.
    resetn = 1'b1;
    push_frame({8{7'h40}}, {{7{7'h7F}}, 7'h40}, 8'h00);
    check_frame(1'b0, 32'd0);

    for (int v = 0; v < 5; v++) begin
      data    = vec[v].data;
      dp_mask = vec[v].mask;
      wait_frame();
      push_frame(vec[v].seg_l0, vec[v].seg_l1, vec[v].mask);
      check_frame(1'b0, 32'd0);
    end

    // Mid-frame store is invisible until the next wrap.
    data    = 32'h1111_1111;
    dp_mask = 8'h00;
    wait_frame();
    push_frame({8{7'h79}}, {8{7'h79}}, 8'h00);
    check_frame(1'b1, 32'h2222_2222);
    push_frame({8{7'h24}}, {8{7'h24}}, 8'h00);
    check_frame(1'b0, 32'd0);

    // Enable dropped during digit 5 for 10 cycles, then resumes mid-digit.
    for (int i = 1; i <= 42; i++) begin
      @(posedge io_clk); #1;
      if (i >= 23 && i <= 32) begin
        check_dark("disabled");
      end else begin
        j = (i <= 22) ? i : i - 10;
        an_exp = 8'(~(8'd1 << ((j - 1) / 4)));
        chk("en_an", 32'(an), 32'(an_exp));
        chk("en_seg", 32'(seg), 32'h24);
        chk("en_fd", 32'(frame_done), 32'(i == 42));
      end
      if (i == 22) enable = 1'b0;
      if (i == 32) enable = 1'b1;
    end

    // Asynchronous reset mid-frame, then a fresh zero frame.
    data = 32'h3333_3333;
    repeat (9) @(posedge io_clk);
    #1;
    resetn = 1'b0;
    #1;
    check_dark("async_reset");
    repeat (2) begin
      @(posedge io_clk); #1;
    end
    check_dark("reset_hold");
    resetn = 1'b1;
    push_frame({8{7'h40}}, {{7{7'h7F}}, 7'h40}, 8'h00);
    check_frame(1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
